a_driver: RTL and testbench



---
 rtl/a_driver_pkg.sv | 21 ++
 rtl/a_drv_timer.sv | 38 +++
 rtl/a_driver.sv | 137 +++++++++++++
 tb/tb_a_driver.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a_driver_pkg.sv
// a_driver_pkg: shared types and sizing helpers for the a_driver block.
//   state_t    - transaction FSM states (IDLE, WAIT, RESP)
//   TXN_CNT_W  - width of the completed-transaction counter
//   cnt_width  - width of the hold-time down-counter for a given delay
package a_driver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int TXN_CNT_W = 16;

    // Enough bits to hold the value `delay`. Clamped to 1 so an illegal
    // delay still elaborates far enough to report the real error.
    function automatic int cnt_width(input int delay);
        return (delay < 1) ? 1 : $clog2(delay + 1);
    endfunction

endpackage

// File: rtl/a_drv_timer.sv
// a_drv_timer: loadable down-counter that measures how long d1/d2 are held.
//   clk      - clock, rising edge
//   rst      - synchronous reset, active-high (count cleared to 0)
//   load     - load strobe, takes priority over counting
//   load_val - value loaded on load
//   en       - count down by one per cycle while non-zero
//   zero     - count is 0
module a_drv_timer
    import a_driver_pkg::*;
#(
    parameter int delay = 5,
    localparam int CW = cnt_width(delay)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          zero
);

    logic [CW-1:0] cnt;

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/a_driver.sv
// a_driver: initiator-side companion for block `a`. Takes one request at a
// time, drives it onto a.d1/a.d2, holds it for `delay` cycles, then captures
// a.d3 and returns it on a valid/ready response stream.
//   clk, rst              - clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   - request handshake; req_d1/req_d2 request payload
//   d1, d2                - registered drive to a.d1 / a.d2
//   d3                    - result from a.d3
//   rsp_valid/rsp_ready   - response handshake; rsp_data captured d3
//   busy                  - transaction in progress (WAIT or RESP)
//   txn_cnt               - completed-transaction count, wraps at 16 bits
// Build option: define A_DRIVER_PARITY_EN to add output rsp_parity, the XOR
// reduction of the captured d3, registered alongside rsp_data.
module a_driver
    import a_driver_pkg::*;
#(
    parameter int g_w1  = 8,
    parameter int g_w2  = 32,
    parameter int g_w3  = 16,
    parameter int delay = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [g_w1-1:0]      req_d1,
    input  logic [g_w2+1:0]      req_d2,
    output logic [g_w1-1:0]      d1,
    output logic [g_w2+1:0]      d2,
    input  logic [g_w3*2-1:0]    d3,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [g_w3*2-1:0]    rsp_data,
`ifdef A_DRIVER_PARITY_EN
    output logic                 rsp_parity,
`endif
    output logic                 busy,
    output logic [TXN_CNT_W-1:0] txn_cnt
);

    localparam int CW = cnt_width(delay);

    if (delay < 1) begin : g_bad_delay
        $error("a_driver: delay must be >= 1");
    end

    state_t state;
    state_t next_state;
    logic   accept;
    logic   rsp_fire;
    logic   hold_done;

    assign accept   = req_valid && req_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

    // Loaded with delay-1 on accept: the WAIT state then lasts exactly
    // `delay` cycles, the last of which is when d3 is captured.
    a_drv_timer #(
        .delay (delay)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (CW'(delay - 1)),
        .en       (state == WAIT),
        .zero     (hold_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                // Held off during reset so a request is never lost to it.
                req_ready = !rst;
                busy      = 1'b0;
                if (req_valid && !rst) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (hold_done) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_fire) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d1        <= '0;
            d2        <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            txn_cnt   <= '0;
`ifdef A_DRIVER_PARITY_EN
            rsp_parity <= 1'b0;
`endif
        end else begin
            // d1/d2 keep their value between transactions.
            if (accept) begin
                d1 <= req_d1;
                d2 <= req_d2;
            end
            if ((state == WAIT) && hold_done) begin
                rsp_data  <= d3;
                rsp_valid <= 1'b1;
`ifdef A_DRIVER_PARITY_EN
                rsp_parity <= ^d3;
`endif
            end
            if (rsp_fire) begin
                rsp_valid <= 1'b0;
                txn_cnt   <= txn_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_a_driver.sv
// tb_a_driver: directed self-checking bench for a_driver. A default-parameter
// instance (u0) covers timing, stalls, back-to-back and mid-transaction reset;
// a small instance (u1, delay=1) covers narrow widths and counter wrap.
module tb_a_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- default instance ----------------
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_d1 = '0;
    logic [33:0] req_d2 = '0;
    logic [7:0]  d1;
    logic [33:0] d2;
    logic [31:0] d3;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        busy;
    logic [15:0] txn_cnt;
    logic        rsp_parity;

    // Stand-in for block `a`: either a directly driven value or a simple
    // function of the driven d1/d2.
    logic        use_model = 1'b0;
    logic [31:0] d3_val = '0;
    always_comb d3 = use_model ? {d2[15:0], 8'h00, d1} : d3_val;

    a_driver u0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_d1    (req_d1),
        .req_d2    (req_d2),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
`ifdef A_DRIVER_PARITY_EN
        .rsp_parity(rsp_parity),
`endif
        .busy      (busy),
        .txn_cnt   (txn_cnt)
    );

`ifndef A_DRIVER_PARITY_EN
    assign rsp_parity = 1'b0;
`endif

    // ---------------- small instance ----------------
    logic        s_rst = 1'b1;
    logic        s_req_valid = 1'b0;
    logic        s_req_ready;
    logic [3:0]  s_req_d1 = '0;
    logic [7:0]  s_req_d2 = '0;
    logic [3:0]  s_d1;
    logic [7:0]  s_d2;
    logic [5:0]  s_d3 = '0;
    logic        s_rsp_valid;
    logic        s_rsp_ready = 1'b1;
    logic [5:0]  s_rsp_data;
    logic        s_busy;
    logic [15:0] s_txn_cnt;
`ifdef A_DRIVER_PARITY_EN
    logic        s_rsp_parity;
`endif

    a_driver #(
        .g_w1  (4),
        .g_w2  (6),
        .g_w3  (3),
        .delay (1)
    ) u1 (
        .clk       (clk),
        .rst       (s_rst),
        .req_valid (s_req_valid),
        .req_ready (s_req_ready),
        .req_d1    (s_req_d1),
        .req_d2    (s_req_d2),
        .d1        (s_d1),
        .d2        (s_d2),
        .d3        (s_d3),
        .rsp_valid (s_rsp_valid),
        .rsp_ready (s_rsp_ready),
        .rsp_data  (s_rsp_data),
`ifdef A_DRIVER_PARITY_EN
        .rsp_parity(s_rsp_parity),
`endif
        .busy      (s_busy),
        .txn_cnt   (s_txn_cnt)
    );

    // One clock: take the edge, land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_req_ready: got %b expected 0", req_ready);
        end
        step();
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid_busy: got %b/%b expected 0/0", rsp_valid, busy);
        end
        vectors++;
        if (d1 !== 8'h00 || d2 !== 34'h0 || rsp_data !== 32'h0 || txn_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_regs: got d1=%h d2=%h rsp=%h cnt=%h expected all zero", d1, d2, rsp_data, txn_cnt);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_basic();
        use_model = 1'b0;
        rsp_ready = 1'b1;
        d3_val    = 32'h1111_1111;
        req_d1    = 8'hA5;
        req_d2    = 34'h3_1234_5678;
        req_valid = 1'b1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL basic_ready: got %b expected 1", req_ready);
        end
        step();                     // accept edge T, now in T+1
        req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            vectors++;
            if (d1 !== 8'hA5 || d2 !== 34'h3_1234_5678) begin
                miscompares++; $display("FAIL basic_hold_T%0d: got d1=%h d2=%h expected a5/312345678", k, d1, d2);
            end
            vectors++;
            if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_wait_T%0d: got valid=%b busy=%b ready=%b expected 0/1/0", k, rsp_valid, busy, req_ready);
            end
            // d3 carries the wanted value only in the sampling cycle.
            if (k == 5) d3_val = 32'hDEAD_BEEF;
            step();
        end
        d3_val = 32'h2222_2222;     // now in T+6
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL basic_rsp: got valid=%b data=%h expected 1/deadbeef", rsp_valid, rsp_data);
        end
        step();                     // T+7
        vectors++;
        if (rsp_valid !== 1'b0 || txn_cnt !== 16'd1 || busy !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_done: got valid=%b cnt=%0d busy=%b ready=%b expected 0/1/0/1", rsp_valid, txn_cnt, busy, req_ready);
        end
        vectors++;
        if (d1 !== 8'hA5 || d2 !== 34'h3_1234_5678) begin
            miscompares++; $display("FAIL basic_keep: got d1=%h d2=%h expected a5/312345678", d1, d2);
        end
    endtask

    task automatic test_stall();
        d3_val    = 32'hCAFE_F00D;
        rsp_ready = 1'b0;
        req_d1    = 8'h3C;
        req_d2    = 34'h2_0000_0001;
        req_valid = 1'b1;
        step();
        // A pending request during the stall must not be taken.
        req_d1 = 8'h77;
        repeat (5) step();          // now in T+6, RESP
        d3_val = 32'h0;
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFE_F00D) begin
                miscompares++; $display("FAIL stall_rsp_%0d: got valid=%b data=%h expected 1/cafef00d", k, rsp_valid, rsp_data);
            end
            vectors++;
            if (req_ready !== 1'b0 || busy !== 1'b1 || d1 !== 8'h3C) begin
                miscompares++; $display("FAIL stall_hold_%0d: got ready=%b busy=%b d1=%h expected 0/1/3c", k, req_ready, busy, d1);
            end
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        vectors++;
        if (rsp_valid !== 1'b0 || txn_cnt !== 16'd2 || busy !== 1'b0) begin
            miscompares++; $display("FAIL stall_release: got valid=%b cnt=%0d busy=%b expected 0/2/0", rsp_valid, txn_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        d3_val    = 32'h5555_AAAA;
        req_d1    = 8'h5A;
        req_d2    = 34'h1_0F0F_0F0F;
        req_valid = 1'b1;
        step();                     // T+1
        req_valid = 1'b0;
        step();                     // T+2
        step();                     // T+3
        rst = 1'b1;
        step();
        vectors++;
        if (rsp_valid !== 1'b0 || d1 !== 8'h00 || d2 !== 34'h0 || txn_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL midrst_regs: got valid=%b d1=%h d2=%h cnt=%h expected 0/0/0/0", rsp_valid, d1, d2, txn_cnt);
        end
        vectors++;
        if (req_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL midrst_ready: got ready=%b busy=%b expected 0/0", req_ready, busy);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL midrst_release: got %b expected 1", req_ready);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++; $display("FAIL midrst_no_rsp_%0d: got valid=%b expected 0", k, rsp_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  d1s [3];
        logic [33:0] d2s [3];
        logic [31:0] exp_rsp [3];
        int          acc_cyc [3];
        int          n_acc;
        int          n_rsp;
        d1s[0] = 8'h11; d2s[0] = 34'h0_0000_1234;
        d1s[1] = 8'h22; d2s[1] = 34'h1_0000_ABCD;
        d1s[2] = 8'h33; d2s[2] = 34'h2_0000_0F0F;
        n_acc = 0;
        n_rsp = 0;
        use_model = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (n_acc < 3) begin
                req_valid = 1'b1;
                req_d1    = d1s[n_acc];
                req_d2    = d2s[n_acc];
            end else begin
                req_valid = 1'b0;
            end
            if (rsp_valid) begin
                vectors++;
                if (n_rsp >= 3) begin
                    miscompares++; $display("FAIL b2b_extra_rsp: got data=%h expected no response", rsp_data);
                end else if (rsp_data !== exp_rsp[n_rsp]) begin
                    miscompares++; $display("FAIL b2b_rsp_%0d: got %h expected %h", n_rsp, rsp_data, exp_rsp[n_rsp]);
                end
                n_rsp++;
            end
            if (req_valid && req_ready) begin
                acc_cyc[n_acc] = cyc;
                exp_rsp[n_acc] = {d2s[n_acc][15:0], 8'h00, d1s[n_acc]};
                n_acc++;
            end
            step();
        end
        req_valid = 1'b0;
        use_model = 1'b0;
        vectors++;
        if (n_acc != 3 || n_rsp != 3) begin
            miscompares++; $display("FAIL b2b_counts: got acc=%0d rsp=%0d expected 3/3", n_acc, n_rsp);
        end else begin
            vectors++;
            if (acc_cyc[1] - acc_cyc[0] != 7 || acc_cyc[2] - acc_cyc[1] != 7) begin
                miscompares++;
                $display("FAIL b2b_spacing: got %0d,%0d expected 7,7", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
        end
        vectors++;
        if (txn_cnt !== 16'd3) begin
            miscompares++; $display("FAIL b2b_txn_cnt: got %0d expected 3", txn_cnt);
        end
    endtask

    task automatic test_small();
        s_rst = 1'b1;
        step();
        step();
        s_rst = 1'b0;
        #1;
        vectors++;
        if (s_req_ready !== 1'b1 || s_txn_cnt !== 16'h0) begin
            miscompares++; $display("FAIL small_reset: got ready=%b cnt=%h expected 1/0", s_req_ready, s_txn_cnt);
        end
        s_req_d1    = 4'h9;
        s_req_d2    = 8'hC3;
        s_d3        = 6'h15;
        s_rsp_ready = 1'b1;
        s_req_valid = 1'b1;
        step();                     // T+1
        s_req_valid = 1'b0;
        vectors++;
        if (s_d1 !== 4'h9 || s_d2 !== 8'hC3 || s_rsp_valid !== 1'b0 || s_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL small_hold: got d1=%h d2=%h valid=%b busy=%b expected 9/c3/0/1", s_d1, s_d2, s_rsp_valid, s_busy);
        end
        s_d3 = 6'h2A;
        step();                     // T+2
        s_d3 = 6'h3F;
        vectors++;
        if (s_rsp_valid !== 1'b1 || s_rsp_data !== 6'h2A) begin
            miscompares++; $display("FAIL small_rsp: got valid=%b data=%h expected 1/2a", s_rsp_valid, s_rsp_data);
        end
        step();                     // T+3
        vectors++;
        if (s_rsp_valid !== 1'b0 || s_txn_cnt !== 16'd1) begin
            miscompares++; $display("FAIL small_done: got valid=%b cnt=%0d expected 0/1", s_rsp_valid, s_txn_cnt);
        end
        // Preload the counter near its top so the wrap is reachable quickly.
        force u1.txn_cnt = 16'hFFFF;
        #1;
        release u1.txn_cnt;
        @(negedge clk);
        s_req_d1    = 4'h4;
        s_req_d2    = 8'h5A;
        s_d3        = 6'h01;
        s_req_valid = 1'b1;
        step();
        s_req_valid = 1'b0;
        step();
        vectors++;
        if (s_rsp_valid !== 1'b1 || s_rsp_data !== 6'h01) begin
            miscompares++; $display("FAIL small_rsp2: got valid=%b data=%h expected 1/01", s_rsp_valid, s_rsp_data);
        end
        step();
        vectors++;
        if (s_txn_cnt !== 16'h0000) begin
            miscompares++; $display("FAIL small_wrap: got %h expected 0000", s_txn_cnt);
        end
    endtask

    task automatic test_parity();
        logic [31:0] vals [2];
        logic        exp_par [2];
        vals[0] = 32'h0000_0007; exp_par[0] = 1'b1;
        vals[1] = 32'h0000_0003; exp_par[1] = 1'b0;
        use_model = 1'b0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            d3_val    = vals[n];
            req_valid = 1'b1;
            step();
            req_valid = 1'b0;
            repeat (5) step();
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_parity !== exp_par[n]) begin
                miscompares++;
                $display("FAIL parity_%0d: got valid=%b parity=%b expected 1/%b", n, rsp_valid, rsp_parity, exp_par[n]);
            end
            step();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_small();
`ifdef A_DRIVER_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
